// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state
// encoding, funct3 size/sign codes and port indices.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Loads and stores share the funct3 encoding space.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dm_arbiter_pick2.sv
// Two-way winner select. Round-robin on contention when DM_ARBITER_RR_EN
// is defined, otherwise port 0 has fixed priority.
module arb_pick2
  import dm_arbiter_pkg::*;
(
  input  logic [1:0] req,
`ifdef DM_ARBITER_RR_EN
  input  logic       last_grant,
`endif
  output logic       gnt_valid,
  output logic       gnt_port
);

  always_comb begin
    gnt_valid = |req;
    gnt_port  = PORT0;
    if (req == 2'b10) begin
      gnt_port = PORT1;
    end
`ifdef DM_ARBITER_RR_EN
    // Contention: hand the port to whoever was not granted last.
    else if (req == 2'b11) begin
      gnt_port = ~last_grant;
    end
`endif
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of dm_control: IDLE -> ACCESS -> RESP.
// Define DM_ARBITER_RR_EN for round-robin arbitration (default: port 0 priority).
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [2:0]    m0_op,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [2:0]    m1_op,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          dm_we,
  output logic [2:0]    dm_op,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  output logic          owner,
  output logic          busy
);

  typedef struct packed {
    logic          we;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  cmd_t          m0_cmd, m1_cmd;
  logic          owner_q, owner_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          gnt_valid, gnt_port;
  logic          resp_live;

  assign m0_cmd = '{we: m0_we, op: m0_op, addr: m0_addr, wdata: m0_wdata};
  assign m1_cmd = '{we: m1_we, op: m1_op, addr: m1_addr, wdata: m1_wdata};

`ifdef DM_ARBITER_RR_EN
  logic last_grant_q, last_grant_d;

  arb_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_port   (gnt_port)
  );
`else
  arb_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      owner_q    <= PORT0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef DM_ARBITER_RR_EN
      last_grant_q <= PORT1;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      owner_q    <= owner_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef DM_ARBITER_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d      = cmd_q;
    owner_d    = owner_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
`ifdef DM_ARBITER_RR_EN
    last_grant_d = last_grant_q;
`endif
    if (state_q == IDLE && gnt_valid) begin
      owner_d = gnt_port;
      cmd_d   = (gnt_port == PORT1) ? m1_cmd : m0_cmd;
`ifdef DM_ARBITER_RR_EN
      last_grant_d = gnt_port;
`endif
    end
    if (state_q == RESP) begin
      if (owner_q == PORT1) m1_rdata_d = dm_rdata;
      else                  m0_rdata_d = dm_rdata;
    end
  end

  // A transaction being reset away in RESP must not release its requester.
  always_comb begin
    resp_live = (state_q == RESP) && reset;
    m0_ack    = resp_live && (owner_q == PORT0);
    m1_ack    = resp_live && (owner_q == PORT1);
    m0_rdata  = m0_ack ? dm_rdata : m0_rdata_q;
    m1_rdata  = m1_ack ? dm_rdata : m1_rdata_q;
    dm_we     = (state_q == ACCESS) && cmd_q.we;
    dm_op     = cmd_q.op;
    dm_addr   = cmd_q.addr;
    dm_wdata  = cmd_q.wdata;
    owner     = owner_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: transaction-level reference model
// (grant times, ack times, ordered memory image) plus directed and random tests.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [2:0]    m0_op = '0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [2:0]    m1_op = '0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic          dm_we;
  logic [2:0]    dm_op;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          owner, busy;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dm_we(dm_we), .dm_op(dm_op), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .owner(owner), .busy(busy)
  );

  // Word-wide stand-in for dm_control with a preload backdoor.
  logic [DW-1:0] phys [64];
  logic          bd_we = 1'b0;
  logic [5:0]    bd_idx = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we)      phys[bd_idx] <= bd_data;
    else if (dm_we) phys[dm_addr[7:2]] <= dm_wdata;
    dm_rdata <= phys[dm_addr[7:2]];
  end

  typedef struct {
    bit            we;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
  } txn_t;

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  int            k = 0;
  int            next_free = 0;
  int            g_edge = -100;
  int            g_own = 0;
  bit            g_we = 0;
  logic [2:0]    g_op = '0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0, g_data = '0;
  bit            rr_last = 1;
  logic [DW-1:0] exp_rd [2];
  bit            exp_ok [2];
  bit            ack_now [2];

  // Port agents
  txn_t pq0[$], pq1[$];
  bit   active [2];
  int   gapc [2];
  bit   agent_en = 0;
  logic rst_next = 1'b0;

  int ack_log_p[$];
  int ack_log_k[$];
  int ncmp = 0, nerr = 0;

  task automatic model_edge();
    int e, w;
    e = k + 1;
    if (!reset) begin
      g_edge = -100; next_free = e + 1; rr_last = 1;
      g_own = 0; g_we = 0; g_op = '0; g_addr = '0; g_wdata = '0;
      exp_rd[0] = '0; exp_rd[1] = '0; exp_ok[0] = 1; exp_ok[1] = 1;
    end else if (e >= next_free && (m0_req || m1_req)) begin
      if (m0_req && m1_req) begin
`ifdef DM_ARBITER_RR_EN
        w = rr_last ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = m0_req ? 0 : 1;
      end
      rr_last = (w == 1);
      g_own = w; g_edge = e; next_free = e + 3;
      if (w == 0) begin g_we = m0_we; g_op = m0_op; g_addr = m0_addr; g_wdata = m0_wdata; end
      else        begin g_we = m1_we; g_op = m1_op; g_addr = m1_addr; g_wdata = m1_wdata; end
      if (g_we) ref_mem[g_addr[7:2]] = g_wdata;
      else      g_data = ref_mem[g_addr[7:2]];
    end
  endtask

  task automatic check();
    bit acc, rsp, busy_e;
    bit ea [2];
    acc = (k == g_edge);
    rsp = (k == g_edge + 1);
    busy_e = acc || rsp;
    ea[0] = rsp && reset && (g_own == 0);
    ea[1] = rsp && reset && (g_own == 1);
    ack_now = ea;
    ncmp++; if (m0_ack !== ea[0]) begin nerr++; $display("FAIL m0_ack @%0d: got %b want %b", k, m0_ack, ea[0]); end
    ncmp++; if (m1_ack !== ea[1]) begin nerr++; $display("FAIL m1_ack @%0d: got %b want %b", k, m1_ack, ea[1]); end
    ncmp++; if (busy !== busy_e) begin nerr++; $display("FAIL busy @%0d: got %b want %b", k, busy, busy_e); end
    ncmp++; if (dm_we !== (acc && g_we)) begin nerr++; $display("FAIL dm_we @%0d: got %b want %b", k, dm_we, acc && g_we); end
    ncmp++; if (dm_addr !== g_addr) begin nerr++; $display("FAIL dm_addr @%0d: got %h want %h", k, dm_addr, g_addr); end
    ncmp++; if (dm_op !== g_op) begin nerr++; $display("FAIL dm_op @%0d: got %h want %h", k, dm_op, g_op); end
    ncmp++; if (dm_wdata !== g_wdata) begin nerr++; $display("FAIL dm_wdata @%0d: got %h want %h", k, dm_wdata, g_wdata); end
    if (busy_e) begin
      ncmp++; if (owner !== 1'(g_own)) begin nerr++; $display("FAIL owner @%0d: got %b want %0d", k, owner, g_own); end
    end
    if (m0_ack === 1'b1) begin ack_log_p.push_back(0); ack_log_k.push_back(k); end
    if (m1_ack === 1'b1) begin ack_log_p.push_back(1); ack_log_k.push_back(k); end
    for (int p = 0; p < 2; p++) begin
      if (ea[p]) begin
        if (g_we) exp_ok[p] = 0;
        else begin exp_rd[p] = g_data; exp_ok[p] = 1; end
      end
    end
    if (exp_ok[0]) begin
      ncmp++; if (m0_rdata !== exp_rd[0]) begin nerr++; $display("FAIL m0_rdata @%0d: got %h want %h", k, m0_rdata, exp_rd[0]); end
    end
    if (exp_ok[1]) begin
      ncmp++; if (m1_rdata !== exp_rd[1]) begin nerr++; $display("FAIL m1_rdata @%0d: got %h want %h", k, m1_rdata, exp_rd[1]); end
    end
  endtask

  task automatic set_port(input int p, input txn_t t);
    if (p == 0) begin m0_req = 1; m0_we = t.we; m0_op = t.op; m0_addr = t.addr; m0_wdata = t.wdata; end
    else        begin m1_req = 1; m1_we = t.we; m1_op = t.op; m1_addr = t.addr; m1_wdata = t.wdata; end
  endtask

  task automatic drive_ports();
    txn_t t;
    bit   have;
    if (!agent_en) return;
    for (int p = 0; p < 2; p++) begin
      if (ack_now[p] && active[p]) begin
        active[p] = 0;
        if (p == 0) t = pq0.pop_front(); else t = pq1.pop_front();
      end
      if (!active[p]) begin
        have = (p == 0) ? (pq0.size() > 0) : (pq1.size() > 0);
        if (have) begin
          if (p == 0) t = pq0[0]; else t = pq1[0];
          if (gapc[p] < t.gap) begin
            gapc[p]++;
            if (p == 0) m0_req = 0; else m1_req = 0;
          end else begin
            gapc[p] = 0; active[p] = 1; set_port(p, t);
          end
        end else begin
          if (p == 0) m0_req = 0; else m1_req = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    k++;
    #1 reset = rst_next;
    @(negedge clk);
    check();
    drive_ports();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((pq0.size() > 0 || pq1.size() > 0 || k <= g_edge + 2) && n < budget) begin
      tick(); n++;
    end
    ncmp++;
    if (pq0.size() > 0 || pq1.size() > 0) begin
      nerr++; $display("FAIL run_timeout: pending %0d/%0d want 0/0", pq0.size(), pq1.size());
    end
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] d);
    bd_we = 1; bd_idx = 6'(idx); bd_data = d; ref_mem[idx] = d;
    tick();
    bd_we = 0;
  endtask

  task automatic do_reset();
    rst_next = 0; tick(); tick();
    rst_next = 1; tick();
  endtask

  function automatic txn_t mk(input bit we, input logic [2:0] op, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int gap);
    txn_t t;
    t.we = we; t.op = op; t.addr = a; t.wdata = d; t.gap = gap;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [2:0] lops [5];
    logic [2:0] sops [3];
    bit we;
    lops = '{LB, LH, LW, LBU, LHU};
    sops = '{SB, SH, SW};
    we = 1'($urandom_range(0, 1));
    return mk(we, we ? sops[$urandom_range(0, 2)] : lops[$urandom_range(0, 4)],
              32'($urandom_range(0, 63)) << 2, 32'($urandom), int'($urandom_range(0, 3)));
  endfunction

  task automatic init_mem();
    agent_en = 0; rst_next = 0;
    for (int i = 0; i < 64; i++) preload(i, '0);
  endtask

  task automatic test_reset();
    int k_rel, n;
    m0_req = 1; m0_we = 0; m0_op = LW; m0_addr = 32'h10; m0_wdata = 32'hAAAA_0000;
    m1_req = 1; m1_we = 0; m1_op = LW; m1_addr = 32'h14; m1_wdata = 32'h5555_0000;
    rst_next = 0; tick(); tick();
    ncmp++; if ({busy, m0_ack, m1_ack, dm_we, owner} !== 5'b0) begin nerr++; $display("FAIL reset_ctrl: got %b want 00000", {busy, m0_ack, m1_ack, dm_we, owner}); end
    ncmp++; if (dm_addr !== '0 || m0_rdata !== '0) begin nerr++; $display("FAIL reset_data: got %h/%h want 0/0", dm_addr, m0_rdata); end
    rst_next = 1; tick();
    k_rel = k; n = 0;
    ack_log_k.delete(); ack_log_p.delete();
    while (ack_log_k.size() == 0 && n < 8) begin tick(); n++; end
    ncmp++;
    if (ack_log_k.size() == 0) begin nerr++; $display("FAIL reset_first_ack: got none want edge %0d", k_rel + 2); end
    else if (ack_log_k[0] != k_rel + 2 || ack_log_p[0] != 0) begin
      nerr++; $display("FAIL reset_first_ack: got port %0d edge %0d want port 0 edge %0d", ack_log_p[0], ack_log_k[0], k_rel + 2);
    end
    m0_req = 0; m1_req = 0;
    run(10);
  endtask

  task automatic test_p0_load();
    agent_en = 1;
    preload(4, 32'hDEAD_BEEF);
    ack_log_p.delete(); ack_log_k.delete();
    pq0.push_back(mk(0, LW, 32'h10, 32'h0, 0));
    run(20);
    ncmp++; if (m0_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL p0_load_data: got %h want deadbeef", m0_rdata); end
    ncmp++; if (ack_log_p.size() != 1 || ack_log_p[0] != 0) begin nerr++; $display("FAIL p0_load_acks: got %0d acks want 1 on port 0", ack_log_p.size()); end
  endtask

  task automatic test_store_load();
    pq1.push_back(mk(1, SW, 32'h20, 32'h1234_5678, 0));
    run(20);
    ncmp++; if (phys[8] !== 32'h1234_5678) begin nerr++; $display("FAIL p1_store_mem: got %h want 12345678", phys[8]); end
    pq0.push_back(mk(0, LW, 32'h20, 32'h0, 0));
    run(20);
    ncmp++; if (m0_rdata !== 32'h1234_5678) begin nerr++; $display("FAIL p0_after_p1_store: got %h want 12345678", m0_rdata); end
  endtask

  task automatic test_simultaneous();
    int exp_seq [8];
`ifdef DM_ARBITER_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    do_reset();
    ack_log_p.delete(); ack_log_k.delete();
    for (int i = 0; i < 4; i++) begin
      pq0.push_back(mk(0, LW, 32'(i * 4), 32'h0, 0));
      pq1.push_back(mk(0, LW, 32'(64 + i * 4), 32'h0, 0));
    end
    drive_ports();
    run(60);
    ncmp++;
    if (ack_log_p.size() != 8) begin nerr++; $display("FAIL simul_count: got %0d want 8", ack_log_p.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        ncmp++; if (ack_log_p[i] != exp_seq[i]) begin nerr++; $display("FAIL simul_order[%0d]: got %0d want %0d", i, ack_log_p[i], exp_seq[i]); end
        if (i > 0) begin
          ncmp++; if (ack_log_k[i] - ack_log_k[i-1] != 3) begin nerr++; $display("FAIL simul_spacing[%0d]: got %0d want 3", i, ack_log_k[i] - ack_log_k[i-1]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k0;
    logic [DW-1:0] v [3];
    for (int i = 0; i < 3; i++) begin
      v[i] = 32'($urandom) | 32'h1;
      preload(i, v[i]);
    end
    ack_log_p.delete(); ack_log_k.delete();
    for (int i = 0; i < 3; i++) pq0.push_back(mk(0, LW, 32'(i * 4), 32'h0, 0));
    drive_ports();
    k0 = k;
    run(30);
    ncmp++;
    if (ack_log_k.size() != 3) begin nerr++; $display("FAIL b2b_count: got %0d want 3", ack_log_k.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        ncmp++; if (ack_log_k[i] != k0 + 2 + 3 * i) begin nerr++; $display("FAIL b2b_time[%0d]: got %0d want %0d", i, ack_log_k[i] - k0, 2 + 3 * i); end
      end
    end
    ncmp++; if (m0_rdata !== v[2]) begin nerr++; $display("FAIL b2b_last_data: got %h want %h", m0_rdata, v[2]); end
  endtask

  task automatic test_mid_reset();
    agent_en = 0;
    preload(12, 32'hCAFE_F00D);
    m0_req = 1; m0_we = 0; m0_op = LW; m0_addr = 32'h30; m0_wdata = '0;
    tick();
    m0_req = 0;
    rst_next = 0;
    tick();
    ncmp++; if (m0_ack !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL midrst_resp: got ack %b busy %b want 0 1", m0_ack, busy); end
    rst_next = 1;
    tick();
    ncmp++; if (busy !== 1'b0 || m0_ack !== 1'b0) begin nerr++; $display("FAIL midrst_idle: got busy %b ack %b want 0 0", busy, m0_ack); end
    ncmp++; if (m0_rdata !== '0) begin nerr++; $display("FAIL midrst_rdata: got %h want 0", m0_rdata); end
    run(10);
  endtask

  task automatic test_random();
    agent_en = 1;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      pq0.push_back(rand_txn());
      pq1.push_back(rand_txn());
    end
    run(2000);
  endtask

  initial begin
    exp_rd[0] = '0; exp_rd[1] = '0; exp_ok[0] = 0; exp_ok[1] = 0;
    ack_now[0] = 0; ack_now[1] = 0;
    active[0] = 0; active[1] = 0; gapc[0] = 0; gapc[1] = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    init_mem();
    test_reset();
    test_p0_load();
    test_store_load();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
